// File: rtl/scan_test_controller.sv
// Scan test sequencer for a single-chain full-scan CUT: shift-in, capture,
// overlapped unload, and compare against expected state/PO with pass/fail stats.
module scan_test_controller #(
    parameter int FF    = 18,
    parameter int IN_W  = 14,
    parameter int OUT_W = 14,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop_on_fail,
    input  logic             pat_valid,
    output logic             pat_ready,
    input  logic [IN_W-1:0]  pat_pi,
    input  logic [FF-1:0]    pat_scan_in,
    input  logic [FF-1:0]    pat_exp_st,
    input  logic [OUT_W-1:0] pat_exp_po,
    input  logic             pat_last,
    output logic [IN_W-1:0]  cut_pi,
    output logic             NbarT,
    output logic             Si,
    input  logic             So,
    input  logic [OUT_W-1:0] cut_po,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CW-1:0]    mismatch_count,
    output logic [CW-1:0]    pat_count,
    output logic [CW-1:0]    first_fail_pat
);

    typedef enum logic [2:0] {
        IDLE, LOAD, SHIFT, CAPTURE, CHECK, UNLOAD, FINAL, DONE
    } state_t;

    localparam int CNT_W = (FF > 1) ? $clog2(FF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FF - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [FF-1:0]    sh_in;
    logic [FF-1:0]    sh_out;
    logic [FF-1:0]    exp_st;
    logic [FF-1:0]    prev_exp;
    logic [OUT_W-1:0] exp_po;
    logic [OUT_W-1:0] po_s;
    logic             last;
    logic             first;
    logic             sof;

    logic chk_mis;
    logic fin_mis;
    logic mis;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    // The first pattern has nothing meaningful to unload, so only its PO counts.
    assign chk_mis = first ? (po_s != exp_po)
                           : ({sh_out, po_s} != {prev_exp, exp_po});
    assign fin_mis = (sh_out != exp_st);
    assign mis     = ((state == CHECK) && chk_mis) || ((state == FINAL) && fin_mis);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            sh_in          <= '0;
            sh_out         <= '0;
            exp_st         <= '0;
            prev_exp       <= '0;
            exp_po         <= '0;
            po_s           <= '0;
            last           <= 1'b0;
            first          <= 1'b0;
            sof            <= 1'b0;
            pat_ready      <= 1'b0;
            cut_pi         <= '0;
            NbarT          <= 1'b0;
            Si             <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fail           <= 1'b0;
            mismatch_count <= '0;
            pat_count      <= '0;
            first_fail_pat <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        fail           <= 1'b0;
                        mismatch_count <= '0;
                        pat_count      <= '0;
                        first_fail_pat <= '0;
                        first          <= 1'b1;
                        sof            <= stop_on_fail;
                        done           <= 1'b0;
                        busy           <= 1'b1;
                        pat_ready      <= 1'b1;
                        state          <= LOAD;
                    end
                end
                LOAD: begin
                    if (pat_valid) begin
                        cut_pi    <= pat_pi;
                        exp_po    <= pat_exp_po;
                        exp_st    <= pat_exp_st;
                        prev_exp  <= exp_st;
                        last      <= pat_last;
                        sh_in     <= pat_scan_in;
                        Si        <= pat_scan_in[0];
                        NbarT     <= 1'b1;
                        pat_ready <= 1'b0;
                        cnt       <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT, UNLOAD: begin
                    // So is the pre-shift chain bit at this position.
                    sh_in       <= sh_in >> 1;
                    sh_out[cnt] <= So;
                    cnt         <= cnt + 1'b1;
                    Si          <= sh_in[1];
                    if (cnt == CNT_LAST) begin
                        NbarT <= 1'b0;
                        Si    <= 1'b0;
                        state <= (state == SHIFT) ? CAPTURE : FINAL;
                    end
                end
                CAPTURE: begin
                    po_s      <= cut_po;
                    pat_count <= sat_inc(pat_count);
                    state     <= CHECK;
                end
                CHECK: begin
                    first <= 1'b0;
                    if (chk_mis && sof) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (last) begin
                        sh_in <= '0;
                        NbarT <= 1'b1;
                        Si    <= 1'b0;
                        cnt   <= '0;
                        state <= UNLOAD;
                    end else begin
                        pat_ready <= 1'b1;
                        state     <= LOAD;
                    end
                end
                FINAL: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase

            // Compare bookkeeping shared by CHECK and FINAL.
            if (mis) begin
                mismatch_count <= sat_inc(mismatch_count);
                fail           <= 1'b1;
                if (!fail)
                    first_fail_pat <= pat_count;
            end
        end
    end

endmodule

// File: tb/tb_scan_test_controller.sv
// Randomized bench for scan_test_controller with a behavioural scan CUT and a
// pattern-level reference model of the expected session results.
module tb_scan_test_controller;

    localparam int FF    = 4;
    localparam int IN_W  = 2;
    localparam int OUT_W = 2;
    localparam int CW    = 16;
    localparam int MAXP  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             stop_on_fail = 1'b0;
    logic             pat_valid = 1'b0;
    logic             pat_ready;
    logic [IN_W-1:0]  pat_pi = '0;
    logic [FF-1:0]    pat_scan_in = '0;
    logic [FF-1:0]    pat_exp_st = '0;
    logic [OUT_W-1:0] pat_exp_po = '0;
    logic             pat_last = 1'b0;
    logic [IN_W-1:0]  cut_pi;
    logic             NbarT;
    logic             Si;
    logic             So;
    logic [OUT_W-1:0] cut_po;
    logic             busy;
    logic             done;
    logic             fail;
    logic [CW-1:0]    mismatch_count;
    logic [CW-1:0]    pat_count;
    logic [CW-1:0]    first_fail_pat;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    scan_test_controller #(.FF(FF), .IN_W(IN_W), .OUT_W(OUT_W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop_on_fail(stop_on_fail),
        .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_pi(pat_pi),
        .pat_scan_in(pat_scan_in), .pat_exp_st(pat_exp_st), .pat_exp_po(pat_exp_po),
        .pat_last(pat_last), .cut_pi(cut_pi), .NbarT(NbarT), .Si(Si), .So(So),
        .cut_po(cut_po), .busy(busy), .done(done), .fail(fail),
        .mismatch_count(mismatch_count), .pat_count(pat_count),
        .first_fail_pat(first_fail_pat)
    );

    // Behavioural CUT: So = q[0], shift moves toward bit 0; capture logic is
    // idempotent so the extra functional clocks in CHECK/LOAD leave it unchanged.
    logic [FF-1:0] q = '0;
    logic fault_po0 = 1'b0;
    logic fault_sc1 = 1'b0;

    function automatic logic [FF-1:0] fixs(input logic [FF-1:0] x, input logic sc1);
        return sc1 ? (x & 4'b1101) : x;
    endfunction

    function automatic logic [FF-1:0] capf(input logic [FF-1:0] s, input logic [IN_W-1:0] pi);
        return (s | {pi[1], 1'b0, pi[0], 1'b0}) & {1'b1, ~pi[0], 1'b1, ~pi[1]};
    endfunction

    function automatic logic [OUT_W-1:0] pof(input logic [FF-1:0] s, input logic [IN_W-1:0] pi,
                                             input logic po0);
        logic [OUT_W-1:0] r;
        r = {s[3] ^ pi[1], s[2] & pi[0]};
        if (po0) r[0] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        if (NbarT) q <= fixs({Si, q[FF-1:1]}, fault_sc1);
        else       q <= fixs(capf(q, cut_pi), fault_sc1);
    end
    assign So     = q[0];
    assign cut_po = pof(q, cut_pi, fault_po0);

    logic [FF-1:0]    p_scan[MAXP];
    logic [FF-1:0]    p_exp_st[MAXP];
    logic [IN_W-1:0]  p_pi[MAXP];
    logic [OUT_W-1:0] p_exp_po[MAXP];
    int               p_gap[MAXP];
    int               np;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_pat(input int k, input logic [FF-1:0] scan, input logic [IN_W-1:0] pi,
                           input int gap);
        p_scan[k]   = scan;
        p_pi[k]     = pi;
        p_gap[k]    = gap;
        p_exp_po[k] = pof(scan, pi, 1'b0);
        p_exp_st[k] = capf(scan, pi);
    endtask

    task automatic chain(input logic [FF-1:0] s_in, input logic [FF-1:0] din, input logic sc1,
                         output logic [FF-1:0] s_out, output logic [FF-1:0] dout);
        logic [FF-1:0] s;
        s = s_in;
        dout = '0;
        for (int i = 0; i < FF; i++) begin
            dout[i] = s[0];
            s = fixs({din[i], s[FF-1:1]}, sc1);
        end
        s_out = s;
    endtask

    // Pattern-level reference: what the session should report.
    task automatic ref_session(input logic sof, output int n_app, output int mcnt,
                               output int ffp, output logic stopped, output int cyc);
        logic [FF-1:0]    s, nxt, out;
        logic [OUT_W-1:0] po;
        logic             mis, failing;
        s = '0; mcnt = 0; ffp = 0; failing = 0; stopped = 0; n_app = 0; cyc = 0;
        for (int k = 0; k < np; k++) begin
            chain(s, p_scan[k], fault_sc1, nxt, out);
            s = nxt;
            po = pof(s, p_pi[k], fault_po0);
            s = fixs(capf(s, p_pi[k]), fault_sc1);
            n_app = k + 1;
            cyc += p_gap[k] + FF + 3;
            mis = (po != p_exp_po[k]) || (k > 0 && out != p_exp_st[k-1]);
            if (mis) begin
                mcnt++;
                if (!failing) ffp = k + 1;
                failing = 1;
                if (sof) begin
                    stopped = 1;
                    return;
                end
            end
        end
        chain(s, '0, fault_sc1, nxt, out);
        cyc += FF + 1;
        if (out != p_exp_st[np-1]) begin
            mcnt++;
            if (!failing) ffp = np;
        end
    endtask

    task automatic pulse_start(input logic sof);
        @(negedge clk);
        stop_on_fail = sof;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_session(input string name, input logic sof, output int cycles);
        int   n_app, mcnt, ffp, cyc, idx, w, shifts;
        logic stopped, acc, nb, rdy, fin;
        ref_session(sof, n_app, mcnt, ffp, stopped, cyc);
        pulse_start(sof);
        cycles = 0; idx = 0; w = 0; shifts = 0; fin = 0;
        for (int t = 0; t < 2000 && !fin; t++) begin
            @(negedge clk);
            rdy = pat_ready;
            if (rdy && idx < np && w >= p_gap[idx]) begin
                pat_valid   = 1'b1;
                pat_scan_in = p_scan[idx];
                pat_pi      = p_pi[idx];
                pat_exp_st  = p_exp_st[idx];
                pat_exp_po  = p_exp_po[idx];
                pat_last    = (idx == np - 1);
            end else begin
                pat_valid   = 1'b0;
                pat_scan_in = FF'($urandom);
                pat_pi      = IN_W'($urandom);
                pat_exp_st  = FF'($urandom);
                pat_exp_po  = OUT_W'($urandom);
                pat_last    = 1'($urandom);
            end
            if (rdy && !pat_valid && idx > 0)
                chk({name, " nbart_wait"}, 32'(NbarT), 32'd0);
            acc = rdy && pat_valid;
            nb  = NbarT;
            @(posedge clk);
            cycles++;
            if (nb) shifts++;
            if (acc) begin idx++; w = 0; end
            else if (rdy) w++;
            #1 fin = done;
        end
        pat_valid = 1'b0;
        chk({name, " done_seen"}, 32'(fin), 32'd1);
        chk({name, " cycles"}, 32'(cycles), 32'(cyc));
        chk({name, " accepted"}, 32'(idx), 32'(n_app));
        chk({name, " shifts"}, 32'(shifts), 32'(n_app * FF + (stopped ? 0 : FF)));
        chk({name, " pat_count"}, 32'(pat_count), 32'(n_app));
        chk({name, " mismatch_count"}, 32'(mismatch_count), 32'(mcnt));
        chk({name, " fail"}, 32'(fail), 32'(mcnt != 0));
        chk({name, " first_fail_pat"}, 32'(first_fail_pat), 32'(ffp));
        chk({name, " busy"}, 32'(busy), 32'd0);
    endtask

    task automatic directed_set(input int gap);
        np = 3;
        set_pat(0, 4'b0101, 2'b01, 0);
        set_pat(1, 4'b1010, 2'b10, gap);
        set_pat(2, 4'b0111, 2'b11, gap);
    endtask

    int c;
    int w0;

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst pat_ready", 32'(pat_ready), 32'd0);
        chk("rst NbarT", 32'(NbarT), 32'd0);
        chk("rst Si", 32'(Si), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst fail", 32'(fail), 32'd0);
        chk("rst cut_pi", 32'(cut_pi), 32'd0);
        chk("rst counts", 32'(mismatch_count | pat_count | first_fail_pat), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        directed_set(0);
        run_session("clean", 1'b0, c);
        chk("clean cycles_26", 32'(c), 32'd26);

        fault_po0 = 1'b1;
        run_session("po0_cont", 1'b0, c);
        chk("po0_cont ffp_2", 32'(first_fail_pat), 32'd2);
        run_session("po0_stop", 1'b1, c);
        chk("po0_stop count_2", 32'(pat_count), 32'd2);
        fault_po0 = 1'b0;

        fault_sc1 = 1'b1;
        np = 1;
        set_pat(0, 4'b1111, 2'b00, 0);
        run_session("sc1", 1'b0, c);
        chk("sc1 mcnt_1", 32'(mismatch_count), 32'd1);
        chk("sc1 ffp_1", 32'(first_fail_pat), 32'd1);
        fault_sc1 = 1'b0;

        directed_set(10);
        run_session("gap", 1'b0, c);
        chk("gap cycles_46", 32'(c), 32'd46);

        // Abort mid-shift, then a clean session must report fresh results.
        pulse_start(1'b0);
        @(negedge clk);
        pat_valid = 1'b1; pat_scan_in = p_scan[0]; pat_pi = p_pi[0];
        pat_exp_st = p_exp_st[0]; pat_exp_po = p_exp_po[0]; pat_last = 1'b0;
        w0 = 0;
        while (!NbarT && w0 < 20) begin @(posedge clk); #1 w0++; end
        pat_valid = 1'b0;
        chk("midrst shifting", 32'(NbarT), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst NbarT", 32'(NbarT), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst pat_ready", 32'(pat_ready), 32'd0);
        chk("midrst pat_count", 32'(pat_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        directed_set(0);
        run_session("after_rst", 1'b0, c);

        for (int r = 0; r < 25; r++) begin
            np = $urandom_range(1, 6);
            for (int k = 0; k < np; k++) begin
                set_pat(k, FF'($urandom), IN_W'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
                if ($urandom_range(0, 5) == 0) p_exp_st[k] ^= FF'(1 << $urandom_range(0, FF - 1));
                if ($urandom_range(0, 5) == 0) p_exp_po[k] ^= OUT_W'(1 << $urandom_range(0, OUT_W - 1));
            end
            fault_po0 = ($urandom_range(0, 3) == 0);
            fault_sc1 = ($urandom_range(0, 3) == 0);
            run_session($sformatf("rnd%0d", r), 1'($urandom), c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
